dline_fill: RTL and testbench

DLINE_FILL -- requirements
Module: dline_fill

---
 rtl/dline_fill_pkg.sv | 20 ++
 rtl/dline_fill_iscachable.sv | 27 ++
 rtl/dline_fill.sv | 230 +++++++++++++++++++++++
 tb/tb_dline_fill.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dline_fill_pkg.sv
// dline_fill_pkg -- shared definitions for the data-cache line-fill engine.
//
// Contents:
//   DEF_LGLINE       default log2(words per line)
//   REGION_BITS      number of top address bits that select a memory region
//   CACHABLE_REGION  region number whose addresses are cachable
//   state_e          fill-engine state encoding (IDLE / FILL / SINGLE)
package dline_fill_pkg;

  localparam int unsigned DEF_LGLINE      = 3;
  localparam int unsigned REGION_BITS     = 4;
  localparam logic [3:0]  CACHABLE_REGION = 4'h1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SINGLE = 2'd2
  } state_e;

endpackage

// File: rtl/dline_fill_iscachable.sv
// iscachable -- address cachability decision for dline_fill.
//
// An address is cachable when its top REGION_BITS bits equal CACHABLE_REGION
// (for AW=30 that is word addresses 0x4000000..0x7FFFFFF).
//
// Parameters:
//   AW          word-address width
// Ports:
//   i_addr      in  AW  word address to classify
//   o_cachable  out 1   1 = address may be cached (line fill), 0 = uncached
module iscachable
  import dline_fill_pkg::*;
#(
  parameter int unsigned AW = 30
) (
  input  logic [AW-1:0] i_addr,
  output logic          o_cachable
);

  logic [AW-1:0] region;

  always_comb begin
    region     = i_addr >> (AW - REGION_BITS);
    o_cachable = (region == AW'(CACHABLE_REGION));
  end

endmodule

// File: rtl/dline_fill.sv
// dline_fill -- data-cache line-fill engine on a pipelined Wishbone master.
//
// A read miss on a cachable address fetches a whole line (2^LGLINE words)
// with one strobe per word, writing each returned word into the cache RAM.
// A miss on a non-cachable address performs one single-word read and returns
// the word on o_data. i_wb_err aborts with an o_err pulse; i_clear aborts
// silently.
//
// Build option:
//   DLINE_FILL_CWF_EN  when defined, a line fill starts at the missed word and
//                      wraps modulo the line size (critical word first);
//                      otherwise it starts at word offset 0.
//
// Parameters: AW word-address width, DW data width, LGLINE log2 words/line.
// Ports:
//   i_clk, i_reset           clock; asynchronous active-high reset
//   i_req, i_addr            miss request (taken only while o_busy=0)
//   i_clear                  abort any transaction in progress
//   o_busy                   transaction in progress
//   o_wb_cyc/stb/addr        Wishbone master request
//   i_wb_stall/ack/err/data  Wishbone slave response
//   o_wr, o_wr_addr, o_wr_data  cache-RAM write port (offset within line)
//   o_line_valid, o_tag      line at o_tag is complete and valid
//   o_done, o_err            one-cycle completion / bus-error pulses
//   o_data                   uncached read word, valid with o_done
module dline_fill
  import dline_fill_pkg::*;
#(
  parameter int unsigned AW     = 30,
  parameter int unsigned DW     = 32,
  parameter int unsigned LGLINE = DEF_LGLINE
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req,
  input  logic [AW-1:0]        i_addr,
  input  logic                 i_clear,
  output logic                 o_busy,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic [AW-1:0]        o_wb_addr,
  input  logic                 i_wb_stall,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_err,
  input  logic [DW-1:0]        i_wb_data,
  output logic                 o_wr,
  output logic [LGLINE-1:0]    o_wr_addr,
  output logic [DW-1:0]        o_wr_data,
  output logic                 o_line_valid,
  output logic [AW-LGLINE-1:0] o_tag,
  output logic                 o_done,
  output logic                 o_err,
  output logic [DW-1:0]        o_data
);

  localparam int unsigned TW = AW - LGLINE;
  // Counters are LGLINE+1 bits wide; LAST_CNT marks the final word of a line.
  localparam logic [LGLINE:0]   LAST_CNT = {1'b0, {LGLINE{1'b1}}};
  localparam logic [LGLINE:0]   CNT_ONE  = (LGLINE+1)'(1);
  localparam logic [LGLINE-1:0] OFF_ONE  = LGLINE'(1);

  state_e              state_q;
  logic                cyc_q;
  logic                stb_q;
  logic [AW-1:0]       wb_addr_q;
  logic                wr_q;
  logic [LGLINE-1:0]   wr_addr_q;
  logic [DW-1:0]       wr_data_q;
  logic                line_valid_q;
  logic [TW-1:0]       tag_q;
  logic                done_q;
  logic                err_q;
  logic [DW-1:0]       data_q;
  logic [LGLINE:0]     stb_cnt_q;
  logic [LGLINE:0]     ack_cnt_q;
  logic [LGLINE-1:0]   off0_q;      // word offset of the first strobe of a fill

  logic                cachable;
  logic [LGLINE-1:0]   start_off_d;
  logic [LGLINE-1:0]   wr_off_d;
  logic                stb_take;
  logic                ack_take;
  logic                err_take;

  iscachable #(
    .AW(AW)
  ) u_iscachable (
    .i_addr    (i_addr),
    .o_cachable(cachable)
  );

  always_comb begin
`ifdef DLINE_FILL_CWF_EN
    start_off_d = i_addr[LGLINE-1:0];
`else
    start_off_d = '0;
`endif
    // Acks return in strobe order, so the n-th ack belongs to offset off0+n.
    wr_off_d = off0_q + ack_cnt_q[LGLINE-1:0];
    stb_take = stb_q && !i_wb_stall;
    // Responses outside a bus cycle are ignored.
    ack_take = cyc_q && i_wb_ack;
    err_take = cyc_q && i_wb_err;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      wb_addr_q    <= '0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      stb_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      off0_q       <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (i_clear) begin
        state_q      <= S_IDLE;
        cyc_q        <= 1'b0;
        stb_q        <= 1'b0;
        line_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_req) begin
              cyc_q     <= 1'b1;
              stb_q     <= 1'b1;
              stb_cnt_q <= '0;
              ack_cnt_q <= '0;
              if (cachable) begin
                state_q      <= S_FILL;
                tag_q        <= i_addr[AW-1:LGLINE];
                off0_q       <= start_off_d;
                wb_addr_q    <= {i_addr[AW-1:LGLINE], start_off_d};
                line_valid_q <= 1'b0;
              end else begin
                state_q   <= S_SINGLE;
                wb_addr_q <= i_addr;
              end
            end
          end

          S_FILL: begin
            if (err_take) begin
              state_q      <= S_IDLE;
              cyc_q        <= 1'b0;
              stb_q        <= 1'b0;
              err_q        <= 1'b1;
              line_valid_q <= 1'b0;
            end else begin
              if (stb_take) begin
                stb_cnt_q <= stb_cnt_q + CNT_ONE;
                // Only the offset bits advance, so the fill wraps inside the line.
                wb_addr_q[LGLINE-1:0] <= wb_addr_q[LGLINE-1:0] + OFF_ONE;
                if (stb_cnt_q == LAST_CNT) begin
                  stb_q <= 1'b0;
                end
              end
              if (ack_take) begin
                wr_q      <= 1'b1;
                wr_addr_q <= wr_off_d;
                wr_data_q <= i_wb_data;
                ack_cnt_q <= ack_cnt_q + CNT_ONE;
                if (ack_cnt_q == LAST_CNT) begin
                  state_q      <= S_IDLE;
                  cyc_q        <= 1'b0;
                  stb_q        <= 1'b0;
                  done_q       <= 1'b1;
                  line_valid_q <= 1'b1;
                end
              end
            end
          end

          S_SINGLE: begin
            if (err_take) begin
              state_q      <= S_IDLE;
              cyc_q        <= 1'b0;
              stb_q        <= 1'b0;
              err_q        <= 1'b1;
              line_valid_q <= 1'b0;
            end else begin
              if (stb_take) begin
                stb_q <= 1'b0;
              end
              if (ack_take) begin
                state_q <= S_IDLE;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                data_q  <= i_wb_data;
                done_q  <= 1'b1;
              end
            end
          end

          default: begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy       = (state_q != S_IDLE);
  assign o_wb_cyc     = cyc_q;
  assign o_wb_stb     = stb_q;
  assign o_wb_addr    = wb_addr_q;
  assign o_wr         = wr_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_line_valid = line_valid_q;
  assign o_tag        = tag_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_data       = data_q;

endmodule

// File: tb/tb_dline_fill.sv
// tb_dline_fill -- scoreboard bench for dline_fill (default parameters).
// A Wishbone slave model answers strobes; the driver pushes the expected
// strobe addresses and cache/completion events into queues when it issues a
// request, and a monitor pops and compares whenever the DUT emits them.
module tb_dline_fill;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int LG = 3;
  localparam int NW = 8;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_clear = 1'b0;
  logic          o_busy;
  logic          o_wb_cyc, o_wb_stb;
  logic [AW-1:0] o_wb_addr;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_ack = 1'b0;
  logic          i_wb_err = 1'b0;
  logic [DW-1:0] i_wb_data = '0;
  logic          o_wr;
  logic [LG-1:0] o_wr_addr;
  logic [DW-1:0] o_wr_data;
  logic          o_line_valid;
  logic [AW-LG-1:0] o_tag;
  logic          o_done, o_err;
  logic [DW-1:0] o_data;

  dline_fill #(.AW(AW), .DW(DW), .LGLINE(LG)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
    .i_clear(i_clear), .o_busy(o_busy), .o_wb_cyc(o_wb_cyc),
    .o_wb_stb(o_wb_stb), .o_wb_addr(o_wb_addr), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
    .o_wr(o_wr), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_line_valid(o_line_valid), .o_tag(o_tag), .o_done(o_done),
    .o_err(o_err), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          kind;
    logic [2:0]  off;
    logic [31:0] data;
    logic        lv;
    logic [26:0] tag;
    bit          single;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] strb_q[$];

  // Memory contents seen through the slave.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == 30'h10) return 32'hDEADBEEF;
    return {a, 2'b01} ^ 32'h5A5A1234;
  endfunction

  function automatic bit is_cach(input logic [AW-1:0] a);
    return a[29:26] == 4'h1;
  endfunction

  // Slave knobs (written only by the driver between transactions).
  int stall_mode = 0;   // 0 none, 1 random, 2 three-cycle stall after 3 strobes
  bit ack_gaps   = 0;
  int err_at     = 0;   // ack number answered with err (0 = never)

  // Slave state.
  logic [AW-1:0] pend[$];
  int            ack_idx = 0;
  int            strb_cnt = 0;
  int            stall_run = 0;
  logic          prev_cyc = 1'b0;

  always @(negedge clk) begin : slave
    logic [AW-1:0] pa;
    if (!o_wb_cyc) begin
      pend.delete();
      i_wb_ack   = 1'b0;
      i_wb_err   = 1'b0;
      i_wb_stall = 1'b0;
    end else begin
      if (!prev_cyc) begin
        ack_idx   = 0;
        strb_cnt  = 0;
        stall_run = 0;
      end
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (pend.size() > 0 && !(ack_gaps && $urandom_range(0, 3) == 0)) begin
        pa = pend.pop_front();
        ack_idx++;
        i_wb_data = mem_word(pa);
        i_wb_ack  = 1'b1;
        if (ack_idx == err_at) i_wb_err = 1'b1;  // ack stays high: err must win
      end
      case (stall_mode)
        1: i_wb_stall = ($urandom_range(0, 2) == 0);
        2: begin
          i_wb_stall = (strb_cnt == 3 && stall_run < 3);
          if (i_wb_stall) stall_run++;
        end
        default: i_wb_stall = 1'b0;
      endcase
      if (o_wb_stb && !i_wb_stall) begin
        if (strb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL strobe_extra addr=%0h expected no strobe", o_wb_addr);
        end else begin
          chk("strobe_addr", o_wb_addr, strb_q.pop_front());
        end
        pend.push_back(o_wb_addr);
        strb_cnt++;
      end
    end
    prev_cyc = o_wb_cyc;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (o_wr) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_unexpected off=%0h expected none", o_wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_kind", e.kind, K_WR);
        chk("wr_addr", o_wr_addr, e.off);
        chk("wr_data", o_wr_data, e.data);
      end
    end
    if (o_done) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk("done_kind", e.kind, K_DONE);
        chk("done_cyc", o_wb_cyc, 1'b0);
        chk("done_line_valid", o_line_valid, e.lv);
        if (e.single) chk("done_data", o_data, e.data);
        else          chk("done_tag", o_tag, e.tag);
      end
    end
    if (o_err) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL err_unexpected actual=1 expected=0");
      end else begin
        e = exp_q.pop_front();
        chk("err_kind", e.kind, K_ERR);
        chk("err_cyc", {o_wb_cyc, o_wb_stb}, 2'b00);
        chk("err_line_valid", o_line_valid, 1'b0);
      end
    end
  end

  logic lv_model = 1'b0;

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_cyc_stb"}, {o_wb_cyc, o_wb_stb}, 2'b00);
    chk({tag, "_pulses"}, {o_wr, o_done, o_err}, 3'b000);
    chk({tag, "_line_valid"}, o_line_valid, 1'b0);
    chk({tag, "_wb_addr"}, o_wb_addr, 0);
    chk({tag, "_tag"}, o_tag, 0);
    chk({tag, "_wr_data"}, o_wr_data, 0);
    chk({tag, "_data"}, o_data, 0);
  endtask

  task automatic recover();
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    lv_model = 1'b0;
    exp_q.delete();
    strb_q.delete();
  endtask

  // abort_kind: 0 none, 1 bus error on ack abort_n, 2 clear after abort_n
  // writes, 3 reset after abort_n writes.
  task automatic run_txn(input logic [AW-1:0] a, input int abort_kind,
                         input int abort_n, input int smode, input bit gaps);
    bit          c;
    logic [2:0]  st;
    logic [26:0] tg;
    int          nwr;
    int          seen;
    int          budget;
    logic [2:0]  off;
    exp_t        e;
    c  = is_cach(a);
    tg = a[29:3];
`ifdef DLINE_FILL_CWF_EN
    st = a[2:0];
`else
    st = 3'd0;
`endif
    stall_mode = smode;
    ack_gaps   = gaps;
    err_at     = (abort_kind == 1) ? abort_n : 0;

    if (c) begin
      for (int i = 0; i < NW; i++) begin
        off = 3'(int'(st) + i);
        strb_q.push_back({tg, off});
      end
      nwr = (abort_kind == 0) ? NW : (abort_kind == 1) ? abort_n - 1 : abort_n;
      for (int i = 0; i < nwr; i++) begin
        off = 3'(int'(st) + i);
        e = '{kind: K_WR, off: off, data: mem_word({tg, off}), lv: 1'b0, tag: tg, single: 1'b0};
        exp_q.push_back(e);
      end
      if (abort_kind == 0) begin
        e = '{kind: K_DONE, off: 3'd0, data: 32'd0, lv: 1'b1, tag: tg, single: 1'b0};
        exp_q.push_back(e);
      end else if (abort_kind == 1) begin
        e = '{kind: K_ERR, off: 3'd0, data: 32'd0, lv: 1'b0, tag: tg, single: 1'b0};
        exp_q.push_back(e);
      end
    end else begin
      strb_q.push_back(a);
      e = '{kind: K_DONE, off: 3'd0, data: mem_word(a), lv: lv_model, tag: 27'd0, single: 1'b1};
      exp_q.push_back(e);
    end

    @(negedge clk);
    i_req  = 1'b1;
    i_addr = a;
    @(negedge clk);
    i_req = 1'b0;
    chk("start_busy", o_busy, 1'b1);
    chk("start_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b11);
    chk("start_line_valid", o_line_valid, c ? 1'b0 : lv_model);
    if (c) lv_model = 1'b0;
    // A request while busy must be ignored.
    i_req  = 1'b1;
    i_addr = ~a;
    @(negedge clk);
    i_req = 1'b0;

    if (abort_kind >= 2) begin
      seen = 0;
      budget = 200;
      while (seen < abort_n && budget > 0) begin
        @(negedge clk);
        if (o_wr) seen++;
        budget--;
      end
      chk("abort_wr_seen", seen, abort_n);
      if (abort_kind == 2) begin
        i_clear = 1'b1;
        @(negedge clk);
        i_clear = 1'b0;
        chk("clear_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
        chk("clear_busy", o_busy, 1'b0);
        chk("clear_line_valid", o_line_valid, 1'b0);
        chk("clear_no_done_err", {o_done, o_err}, 2'b00);
      end else begin
        #2 i_reset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        i_reset = 1'b0;
      end
      lv_model = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      budget = 300;
      while (o_busy && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (o_busy) begin
        checks++; errors++;
        $display("FAIL txn_timeout busy=1 expected=0 addr=%0h", a);
        recover();
      end
      repeat (2) @(negedge clk);
      chk("end_cyc", o_wb_cyc, 1'b0);
      if (abort_kind == 0) chk("strobe_count", strb_cnt, c ? NW : 1);
      if (c && abort_kind == 0) lv_model = 1'b1;
      else if (abort_kind == 1) lv_model = 1'b0;
      chk("end_line_valid", o_line_valid, lv_model);
    end
    chk("exp_pending", exp_q.size(), 0);
    strb_q.delete();
    exp_q.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [AW-1:0] ra;
    logic [3:0]    nib;
    int            ak, an;
    #1 check_reset_values("reset");
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;

    run_txn(30'h4000005, 0, 0, 0, 1'b0);   // plain fill
    run_txn(30'h0000010, 0, 0, 0, 1'b0);   // uncached read, line stays valid
    run_txn(30'h4000123, 0, 0, 2, 1'b0);   // stall mid-fill
    run_txn(30'h4000200, 1, 4, 0, 1'b0);   // bus error on 4th ack
    run_txn(30'h4000005, 0, 0, 0, 1'b0);
    run_txn(30'h4000046, 2, 2, 0, 1'b0);   // clear after 2 acks
    run_txn(30'h4000005, 0, 0, 0, 1'b0);
    run_txn(30'h400007B, 3, 2, 0, 1'b0);   // reset after 2 acks

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        ra = {4'h1, 26'($urandom)};
        ak = ($urandom_range(0, 4) == 0) ? 1 : 0;
        an = $urandom_range(1, NW);
      end else begin
        nib = 4'($urandom_range(0, 15));
        if (nib == 4'h1) nib = 4'h0;
        ra = {nib, 26'($urandom)};
        ak = 0;
        an = 0;
      end
      run_txn(ra, ak, an, 1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
